// File: rtl/fifo_pkg.sv
// Shared types, defaults and sizing helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_AF_MARGIN  = 2;
  localparam int unsigned DEF_AE_THRESH  = 2;

  // Pointer/count width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param; master drives requests, slave is the FIFO.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
);
  localparam int unsigned CW = ptr_w(DEPTH);

  logic                  flush;
  logic                  clr_err;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clr_err, wr_en, data_in, rd_en,
    input  data_out, fifo_full, fifo_empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, data_in, rd_en,
    output data_out, fifo_full, fifo_empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage array for the FIFO; the read port is registered unless
// SYNC_FIFO_FWFT_EN is defined, in which case it is a combinational lookup.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic                  rst_n,
  input  logic                  rd_en,
`endif
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Array is deliberately left unreset; contents are only valid between pointers.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data = mem_q[rd_addr];
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Output register holds its value between accepted reads.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, thresholds, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is registered read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AF_THRESH  = DEPTH - DEF_AF_MARGIN,
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc_c, rd_acc_c;
  fifo_status_t          status_c;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Flags are a pure decode of the registered occupancy.
  assign status_c.full         = (count_q == PW'(DEPTH));
  assign status_c.empty        = (count_q == '0);
  assign status_c.almost_full  = (count_q >= PW'(AF_THRESH));
  assign status_c.almost_empty = (count_q <= PW'(AE_THRESH));

  assign wr_acc_c = bus.wr_en & ~status_c.full  & ~bus.flush;
  assign rd_acc_c = bus.rd_en & ~status_c.empty & ~bus.flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    // Set wins over clear when a fresh error coincides with clr_err.
    overflow_d  = (overflow_q  & ~bus.clr_err) | (bus.wr_en & status_c.full);
    underflow_d = (underflow_q & ~bus.clr_err) | (bus.rd_en & status_c.empty);
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc_c) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
    .rst_n   (rst_n),
    .rd_en   (rd_acc_c),
`endif
    .wr_en   (wr_acc_c),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (mem_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = status_c.empty ? '0 : mem_rd_data;
`else
  assign bus.data_out = mem_rd_data;
`endif

  assign bus.fifo_full    = status_c.full;
  assign bus.fifo_empty   = status_c.empty;
  assign bus.almost_full  = status_c.almost_full;
  assign bus.almost_empty = status_c.almost_empty;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: queue-based reference model, directed scenarios plus random traffic.
module tb_sync_fifo_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] mdl_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_out = '0;
  logic [DW-1:0] mon_e;
  bit            mdl_ovf = 1'b0;
  bit            mdl_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a plain queue of stored words.
  task automatic model_step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit fl, input bit ce);
    bit full;
    bit empty;
    full    = (mdl_q.size() == DEPTH);
    empty   = (mdl_q.size() == 0);
    mdl_ovf = (mdl_ovf && !ce) || (wr && full);
    mdl_udf = (mdl_udf && !ce) || (rd && empty);
    if (fl) begin
      mdl_q.delete();
    end else begin
      if (rd && !empty) begin
        last_out = mdl_q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
        exp_q.push_back(last_out);
`endif
      end
      if (wr && !full) mdl_q.push_back(d);
    end
  endtask

  task automatic check_status();
    int unsigned n;
    n = mdl_q.size();
    chk("count",        32'(bus.count),        32'(n));
    chk("fifo_full",    32'(bus.fifo_full),    32'(n == DEPTH));
    chk("fifo_empty",   32'(bus.fifo_empty),   32'(n == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    chk("overflow",     32'(bus.overflow),     32'(mdl_ovf));
    chk("underflow",    32'(bus.underflow),    32'(mdl_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_head",    32'(bus.data_out),     (n != 0) ? 32'(mdl_q[0]) : 32'd0);
`else
    chk("data_hold",    32'(bus.data_out),     32'(last_out));
`endif
  endtask

  task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit rd,
                       input bit fl = 1'b0, input bit ce = 1'b0);
    bus.wr_en   = wr;
    bus.data_in = d;
    bus.rd_en   = rd;
    bus.flush   = fl;
    bus.clr_err = ce;
    @(posedge clk);
    model_step(wr, d, rd, fl, ce);
    @(negedge clk);
    check_status();
  endtask

`ifndef SYNC_FIFO_FWFT_EN
  // Monitor: compares each read word the edge after the model saw it popped.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (bus.data_out !== mon_e) begin
        n_err++;
        $display("FAIL rd_data: got %0h expected %0h at %0t", bus.data_out, mon_e, $time);
      end
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] base;
    bit            r_wr, r_rd, r_fl, r_ce;

    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_status();
    rst_n = 1'b1;

    // Fill to full with 0x00..0x0F.
    for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b0);
    // Write while full: rejected, overflow sticky, then cleared.
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    // Drain in order.
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
    // Read while empty: underflow, count stays 0, data unchanged.
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Steady state at 8 with simultaneous read/write; pointers wrap.
    base = 8'($urandom);
    for (int i = 0; i < 8; i++) cycle(1'b1, base + DW'(i), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, base + DW'(8 + i), 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

    // Flush with 5 entries, then a fresh word reads back.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // Asynchronous reset mid-burst at count 9.
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'($urandom), 1'b0);
    bus.wr_en   = 1'b1;
    bus.data_in = 8'($urandom);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_count",        32'(bus.count),        32'd0);
    chk("rst_fifo_empty",   32'(bus.fifo_empty),   32'd1);
    chk("rst_fifo_full",    32'(bus.fifo_full),    32'd0);
    chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
    chk("rst_almost_full",  32'(bus.almost_full),  32'd0);
    chk("rst_overflow",     32'(bus.overflow),     32'd0);
    chk("rst_underflow",    32'(bus.underflow),    32'd0);
    chk("rst_data_out",     32'(bus.data_out),     32'd0);
    mdl_q.delete();
    exp_q.delete();
    last_out    = '0;
    mdl_ovf     = 1'b0;
    mdl_udf     = 1'b0;
    bus.wr_en   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_status();
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // Random mixed traffic with occasional flush and error clear.
    for (int i = 0; i < 400; i++) begin
      r_fl = ($urandom_range(0, 99) < 3);
      r_wr = !r_fl && ($urandom_range(0, 99) < 55);
      r_rd = !r_fl && ($urandom_range(0, 99) < 50);
      r_ce = ($urandom_range(0, 19) == 0);
      cycle(r_wr, 8'($urandom), r_rd, r_fl, r_ce);
    end
    while (mdl_q.size() != 0) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
